// File: rtl/branch_predict.sv
// Direct-mapped branch target buffer with saturating direction counters.
// IF looks up the fetch PC combinationally; ID writes resolved outcomes back.
module branch_predict #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CTR_W   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  output logic        busy,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_uncond,
  input  logic [31:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state;
  logic [IDX_W-1:0]   clr_idx;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [CTR_W-1:0]   ctr_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;
  logic [CTR_W-1:0] u_ctr, ctr_next;
  logic             accept, upd_we, target_we;
  logic             unused_pc_bits;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Low (byte-offset) and high (beyond the tag) PC bits do not take part.
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  assign busy = (state == CLEAR);

  // Outputs are forced quiet while reset is held and for the whole sweep.
  assign l_hit       = ~busy & ~reset & valid[l_idx] & (tag_mem[l_idx] == l_tag);
  assign pred_hit    = l_hit;
  assign pred_taken  = l_hit & ctr_mem[l_idx][CTR_W-1];
  assign pred_target = l_hit ? target_mem[l_idx] : '0;

  assign u_hit     = valid[u_idx] & (tag_mem[u_idx] == u_tag);
  assign u_ctr     = ctr_mem[u_idx];
  assign accept    = upd_valid & ~busy & ~reset;
  assign upd_we    = accept & (u_hit | upd_taken | upd_uncond);
  assign target_we = upd_we & (upd_taken | ~u_hit);

  always_comb begin
    ctr_next = CTR_WEAK;
    if (u_hit) begin
      if (upd_uncond)
        ctr_next = CTR_MAX;
      else if (upd_taken)
        ctr_next = (u_ctr == CTR_MAX) ? CTR_MAX : u_ctr + 1'b1;
      else
        ctr_next = (u_ctr == '0) ? '0 : u_ctr - 1'b1;
    end else if (upd_uncond) begin
      ctr_next = CTR_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (upd_we)
            valid[u_idx] <= 1'b1;
          if (flush) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        CLEAR: begin
          valid[clr_idx] <= 1'b0;
          // A flush mid-sweep restarts the sweep without leaving CLEAR.
          if (flush) begin
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == IDX_LAST)
              state <= IDLE;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
        end
      endcase
    end
  end

  // Payload storage carries no reset so it can sit in distributed RAM.
  always_ff @(posedge clk) begin
    if (upd_we) begin
      tag_mem[u_idx] <= u_tag;
      ctr_mem[u_idx] <= ctr_next;
    end
    if (target_we)
      target_mem[u_idx] <= upd_target;
  end

endmodule

// File: tb/tb_branch_predict.sv
// Directed self-checking bench for branch_predict (64 entries, 8-bit tag, 2-bit counters).
module tb_branch_predict;

  logic        clk = 1'b0;
  logic        reset, flush, busy;
  logic [31:0] lookup_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_uncond;
  logic [31:0] upd_pc, upd_target;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned n;

  branch_predict #(.ENTRIES(64), .TAG_W(8), .CTR_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .busy(busy),
    .lookup_pc(lookup_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_uncond(upd_uncond), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic hit, input logic taken, input logic [31:0] target);
    lookup_pc = pc;
    #1;
    chk({tag, "_hit"}, 32'(pred_hit), 32'(hit));
    chk({tag, "_taken"}, 32'(pred_taken), 32'(taken));
    chk({tag, "_target"}, pred_target, target);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic uncond,
                     input logic [31:0] target);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken;
    upd_uncond = uncond; upd_target = target;
    tick();
    upd_valid = 1'b0; upd_taken = 1'b0; upd_uncond = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_uncond = 1'b0; upd_target = '0;

    // 1: outputs quiet during reset, then a 64-cycle sweep
    look("in_reset", 32'hBFC00010, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    chk("busy_after_reset", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 200) begin
      lookup_pc = $urandom;
      #1;
      chk("sweep_hit_taken", {30'd0, pred_hit, pred_taken}, 32'd0);
      chk("sweep_target", pred_target, 32'h0);
      tick();
      n++;
    end
    chk("reset_sweep_len", n, 32'd64);
    chk("busy_idle", 32'(busy), 32'd0);

    // 2: first taken update allocates weakly taken; same-cycle lookup still misses
    lookup_pc = 32'hBFC00010;
    upd_valid = 1'b1; upd_pc = 32'hBFC00010; upd_taken = 1'b1; upd_target = 32'hBFC00100;
    #1;
    chk("alloc_pre_hit", 32'(pred_hit), 32'd0);
    tick();
    upd_valid = 1'b0; upd_taken = 1'b0;
    look("alloc", 32'hBFC00010, 1'b1, 1'b1, 32'hBFC00100);

    // 3: saturation both ways (ctr 2 -> 3 -> 3 -> 2 -> 1 -> 0 -> 0 -> 0 -> 1 -> 2)
    upd(32'hBFC00010, 1'b1, 1'b0, 32'hBFC00100);
    upd(32'hBFC00010, 1'b1, 1'b0, 32'hBFC00100);
    look("sat_hi", 32'hBFC00010, 1'b1, 1'b1, 32'hBFC00100);
    upd(32'hBFC00010, 1'b0, 1'b0, 32'hDEAD0000);
    look("ctr2", 32'hBFC00010, 1'b1, 1'b1, 32'hBFC00100);
    upd(32'hBFC00010, 1'b0, 1'b0, 32'hDEAD0000);
    look("ctr1", 32'hBFC00010, 1'b1, 1'b0, 32'hBFC00100);
    for (int i = 0; i < 3; i++) upd(32'hBFC00010, 1'b0, 1'b0, 32'hDEAD0000);
    look("sat_lo", 32'hBFC00010, 1'b1, 1'b0, 32'hBFC00100);
    upd(32'hBFC00010, 1'b1, 1'b0, 32'hBFC00100);
    look("from0", 32'hBFC00010, 1'b1, 1'b0, 32'hBFC00100);
    upd(32'hBFC00010, 1'b1, 1'b0, 32'hBFC00100);
    look("from1", 32'hBFC00010, 1'b1, 1'b1, 32'hBFC00100);

    // 4: alias at the same index with a different tag
    look("alias_miss", 32'hBFC00110, 1'b0, 1'b0, 32'h0);
    upd(32'hBFC00110, 1'b0, 1'b0, 32'hBFC00200);
    look("alias_nt", 32'hBFC00110, 1'b0, 1'b0, 32'h0);
    look("orig_kept", 32'hBFC00010, 1'b1, 1'b1, 32'hBFC00100);
    upd(32'hBFC00110, 1'b1, 1'b0, 32'hBFC00200);
    look("alias_alloc", 32'hBFC00110, 1'b1, 1'b1, 32'hBFC00200);
    look("orig_evicted", 32'hBFC00010, 1'b0, 1'b0, 32'h0);

    // 5: same-cycle lookup/update shows old contents, new ones next cycle
    upd(32'hBFC00010, 1'b1, 1'b0, 32'hBFC00100);
    lookup_pc = 32'hBFC00010;
    upd_valid = 1'b1; upd_pc = 32'hBFC00010; upd_taken = 1'b1; upd_target = 32'hBFC00140;
    #1;
    chk("bypass_old", pred_target, 32'hBFC00100);
    tick();
    upd_valid = 1'b0; upd_taken = 1'b0;
    look("bypass_new", 32'hBFC00010, 1'b1, 1'b1, 32'hBFC00140);

    // 6: flush, re-flush 10 cycles later, update dropped while busy
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("busy_after_flush", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 300) begin
      n++;
      flush = (n == 10);
      upd_valid = (n == 70); upd_pc = 32'hBFC00020; upd_taken = 1'b1; upd_target = 32'hBFC00300;
      tick();
    end
    flush = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    chk("flush_sweep_len", n, 32'd74);
    look("flushed", 32'hBFC00010, 1'b0, 1'b0, 32'h0);
    look("dropped_upd", 32'hBFC00020, 1'b0, 1'b0, 32'h0);
    upd(32'hBFC00020, 1'b1, 1'b1, 32'hBFC00400);
    look("uncond_alloc", 32'hBFC00020, 1'b1, 1'b1, 32'hBFC00400);
    upd(32'hBFC00020, 1'b0, 1'b0, 32'hDEAD0000);
    look("uncond_ctr3", 32'hBFC00020, 1'b1, 1'b1, 32'hBFC00400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
